id_ex_pipe_stage: RTL

Parametrised ID→EX pipeline stage that replaces the free-running decode/execute register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, and write-back bypass into held operands. It sits between decode/register-read and execute. Hazard and branch logic can stall execute or kill in-flight instructions without losing data or reading stale register values.

---
 rtl/id_ex_pipe_stage_if.sv | 59 +++++
 rtl/id_ex_pipe_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_stage_if.sv
// id_ex_pipe_stage_if
// Handshake and data bundle for the ID->EX pipeline stage.
//   id_*        : decode-side valid/ready handshake and instruction payload
//   ex_*        : execute-side valid/ready handshake and held payload
//   flush       : synchronous kill of all held entries
//   wb_*        : write-back port used to refresh held operands
//   stall_count : saturating count of cycles execute held the stage off
// Modports:
//   master : upstream/downstream environment (drives id_*, ex_ready, flush, wb_*)
//   slave  : the pipeline stage itself
interface id_ex_pipe_stage_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned REG_BITS     = 5,
    parameter int unsigned CTRL_WIDTH   = 27,
    parameter int unsigned CNT_WIDTH    = 16
);
    logic                      id_valid;
    logic                      id_ready;
    logic [CTRL_WIDTH-1:0]     id_ctrl;
    logic [REG_BITS-1:0]       id_rs1;
    logic [REG_BITS-1:0]       id_rs2;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [3*ADDRESS_BITS-1:0] id_pcs;

    logic                      ex_valid;
    logic                      ex_ready;
    logic [CTRL_WIDTH-1:0]     ex_ctrl;
    logic [REG_BITS-1:0]       ex_rs1;
    logic [REG_BITS-1:0]       ex_rs2;
    logic [DATA_WIDTH-1:0]     ex_rs1_data;
    logic [DATA_WIDTH-1:0]     ex_rs2_data;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [3*ADDRESS_BITS-1:0] ex_pcs;

    logic                      flush;
    logic                      wb_write;
    logic [REG_BITS-1:0]       wb_reg;
    logic [DATA_WIDTH-1:0]     wb_data;
    logic [CNT_WIDTH-1:0]      stall_count;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_pcs,
        output ex_ready, flush, wb_write, wb_reg, wb_data,
        input  id_ready,
        input  ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pcs,
        input  stall_count
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_pcs,
        input  ex_ready, flush, wb_write, wb_reg, wb_data,
        output id_ready,
        output ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rs1_data, ex_rs2_data, ex_imm, ex_pcs,
        output stall_count
    );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage
// ID->EX pipeline register with valid/ready handshake, a two-entry skid
// buffer (MAIN drives execute, SKID catches the instruction accepted while
// execute stalls), synchronous flush, and write-back bypass into every held
// operand so stalled instructions never carry stale register data.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears state and payload
//   bus   : id_ex_pipe_stage_if.slave (id_*/ex_* handshakes, flush, wb_*,
//           stall_count)
module id_ex_pipe_stage #(
    parameter int unsigned CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned REG_BITS     = 5,
    parameter int unsigned CTRL_WIDTH   = 27,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic             clock,
    input  logic             reset,
    id_ex_pipe_stage_if.slave bus
);

    // Parameter sanity; CORE is only an instance tag and has no datapath role.
    if (DATA_WIDTH == 0 || ADDRESS_BITS == 0 || REG_BITS == 0 ||
        CTRL_WIDTH == 0 || CNT_WIDTH == 0 || CORE > 32'h0000_FFFF) begin : g_param_check
        $error("id_ex_pipe_stage: illegal parameter value");
    end

    typedef struct packed {
        logic [CTRL_WIDTH-1:0]     ctrl;
        logic [REG_BITS-1:0]       rs1;
        logic [REG_BITS-1:0]       rs2;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [3*ADDRESS_BITS-1:0] pcs;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    entry_t               main_q, main_d;
    entry_t               skid_q, skid_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;

    entry_t id_entry;
    logic   in_fire;
    logic   out_fire;
    logic   ex_valid;

    // Replace operand data whose stored index matches an active write-back.
    // Register 0 is hard-wired and never refreshed.
    function automatic entry_t bypass(input entry_t e,
                                      input logic we,
                                      input logic [REG_BITS-1:0] r,
                                      input logic [DATA_WIDTH-1:0] d);
        entry_t o;
        o = e;
        if (we && (r != '0)) begin
            if (e.rs1 == r) o.rs1_data = d;
            if (e.rs2 == r) o.rs2_data = d;
        end
        return o;
    endfunction

    always_comb begin
        id_entry.ctrl     = bus.id_ctrl;
        id_entry.rs1      = bus.id_rs1;
        id_entry.rs2      = bus.id_rs2;
        id_entry.rs1_data = bus.id_rs1_data;
        id_entry.rs2_data = bus.id_rs2_data;
        id_entry.imm      = bus.id_imm;
        id_entry.pcs      = bus.id_pcs;
    end

    // Handshake flags decode only from the state register.
    assign ex_valid     = (state_q != EMPTY);
    assign bus.ex_valid = ex_valid;
    assign bus.id_ready = (state_q != FULL);

    assign in_fire  = bus.id_valid && (state_q != FULL);
    assign out_fire = ex_valid && bus.ex_ready;

    always_comb begin
        state_d = state_q;
        // Held entries keep being refreshed by write-back even when idle.
        main_d  = bypass(main_q, bus.wb_write, bus.wb_reg, bus.wb_data);
        skid_d  = bypass(skid_q, bus.wb_write, bus.wb_reg, bus.wb_data);
        stall_d = stall_q;

        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = bypass(id_entry, bus.wb_write, bus.wb_reg, bus.wb_data);
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = bypass(id_entry, bus.wb_write, bus.wb_reg, bus.wb_data);
                end else if (out_fire) begin
                    state_d = EMPTY;
                end else if (in_fire) begin
                    skid_d  = bypass(id_entry, bus.wb_write, bus.wb_reg, bus.wb_data);
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_d  = bypass(skid_q, bus.wb_write, bus.wb_reg, bus.wb_data);
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush wins over any transfer; payload may stay stale.
        if (bus.flush) begin
            state_d = EMPTY;
        end

        if (ex_valid && !bus.ex_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign bus.ex_ctrl     = main_q.ctrl;
    assign bus.ex_rs1      = main_q.rs1;
    assign bus.ex_rs2      = main_q.rs2;
    assign bus.ex_rs1_data = main_q.rs1_data;
    assign bus.ex_rs2_data = main_q.rs2_data;
    assign bus.ex_imm      = main_q.imm;
    assign bus.ex_pcs      = main_q.pcs;
    assign bus.stall_count = stall_q;

endmodule
